// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between NREQ requester memory interfaces.
//  - Round-robin grant, scanning upward from the pointer; the pointer moves
//    to winner+1 after every grant.
//  - One-entry command buffer toward memory (ACT held stable until NEXT).
//  - In-order tag FIFO: each read accepted by memory pushes the issuing
//    requester index; each DRDY beat pops it and steers R_DRDY back.
//
// Ports
//  CLK, RESET            clock, asynchronous active-high reset
//  R_ACT/R_CMD           per-requester request valid / read(1) write(0)
//  R_SIZE/R_ADDRESS/R_DTo per-requester size, byte address, write data
//  R_NEXT                request accepted this cycle (combinational)
//  R_DRDY/R_DTi          read-data valid (per requester) / read data (broadcast)
//  ACT/CMD/SIZE/ADDRESS/DTo  registered memory command
//  NEXT                  memory accepts the command when ACT & NEXT
//  DRDY/DTi              read data beat from memory, in request order
//  ERR                   sticky: DRDY arrived with no outstanding read
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int NREQ   = 4,
  parameter int TDEPTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NREQ-1:0]      R_ACT,
  input  logic [NREQ-1:0]      R_CMD,
  input  logic [2*NREQ-1:0]    R_SIZE,
  input  logic [45*NREQ-1:0]   R_ADDRESS,
  input  logic [32*NREQ-1:0]   R_DTo,
  output logic [NREQ-1:0]      R_NEXT,
  output logic [NREQ-1:0]      R_DRDY,
  output logic [31:0]          R_DTi,
  output logic                 ACT,
  output logic                 CMD,
  output logic [1:0]           SIZE,
  output logic [44:0]          ADDRESS,
  output logic [31:0]          DTo,
  input  logic                 NEXT,
  input  logic                 DRDY,
  input  logic [31:0]          DTi,
  output logic                 ERR
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TDEPTH);
  localparam int CW = TW + 1;

  // Command buffer
  logic          r_act;
  logic          r_cmd;
  logic [1:0]    r_size;
  logic [44:0]   r_addr;
  logic [31:0]   r_dto;
  logic [IW-1:0] r_own;   // requester that owns the buffered command
  logic [IW-1:0] r_rr;    // round-robin pointer (highest-priority index)

  // Read-tag FIFO
  logic [IW-1:0] r_tag [TDEPTH];
  logic [TW-1:0] r_wp;
  logic [TW-1:0] r_rp;
  logic [CW-1:0] r_cnt;

  // Read-return side
  logic [NREQ-1:0] r_rdrdy;
  logic [31:0]     r_rdti;
  logic            r_err;

  logic            w_free;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic            w_room;
  logic [IW-1:0]   w_pop_tag;
  logic [NREQ-1:0] w_elig;
  logic            w_found;
  logic [IW-1:0]   w_win;
  logic            w_grant;
  logic [IW-1:0]   w_rr_next;
  logic [NREQ-1:0] w_next;

  // Buffer can take a new command if empty or being drained this cycle.
  assign w_free  = ~RESET & (~r_act | NEXT);
  assign w_push  = r_act & NEXT & r_cmd;
  assign w_empty = (r_cnt == '0);
  // A beat arriving while empty is still legal if a read is being pushed now;
  // in that case it belongs to the command in the buffer.
  assign w_pop     = DRDY & (~w_empty | w_push);
  assign w_pop_tag = w_empty ? r_own : r_tag[r_rp];
  // Room for one more read, counting the read entering memory this cycle.
  assign w_room  = (r_cnt + CW'(w_push)) < CW'(TDEPTH);

  // NOTE: every signal written in always_comb gets a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = R_ACT[i] & (~R_CMD[i] | w_room);
    end
  end

  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(r_rr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!w_found && w_elig[j]) begin
        w_found = 1'b1;
        w_win   = IW'(j);
      end
    end
  end

  assign w_grant   = w_free & w_found;
  assign w_rr_next = (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_next = '0;
    if (w_grant) w_next[w_win] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_act  <= 1'b0;
      r_cmd  <= 1'b0;
      r_size <= '0;
      r_addr <= '0;
      r_dto  <= '0;
      r_own  <= '0;
      r_rr   <= '0;
    end else if (w_grant) begin
      r_act  <= 1'b1;
      r_cmd  <= R_CMD[w_win];
      r_size <= R_SIZE[int'(w_win)*2 +: 2];
      r_addr <= R_ADDRESS[int'(w_win)*45 +: 45];
      r_dto  <= R_DTo[int'(w_win)*32 +: 32];
      r_own  <= w_win;
      r_rr   <= w_rr_next;
    end else if (NEXT) begin
      r_act  <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // NOTE: the tag storage is not reset; an entry is only read after it has
  // been written, and the occupancy counter alone defines validity.
  always_ff @(posedge CLK) begin
    if (w_push) r_tag[r_wp] <= r_own;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rdrdy <= '0;
      r_rdti  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_rdrdy <= '0;
      if (w_pop)         r_rdrdy[w_pop_tag] <= 1'b1;
      if (DRDY)          r_rdti <= DTi;
      if (DRDY & ~w_pop) r_err <= 1'b1;
    end
  end

  assign R_NEXT  = w_next;
  assign R_DRDY  = r_rdrdy;
  assign R_DTi   = r_rdti;
  assign ACT     = r_act;
  assign CMD     = r_cmd;
  assign SIZE    = r_size;
  assign ADDRESS = r_addr;
  assign DTo     = r_dto;
  assign ERR     = r_err;

endmodule
